// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: issues req/ack bus transactions,
// stalls the pipeline until completion or timeout, and aligns/extends load data.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   output logic        mem_stall,
   output logic [31:0] ReadData,
   output logic        addr_misaligned,
   output logic        bus_error,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dmem_req_q, dmem_req_d;
   logic          dmem_we_q, dmem_we_d;
   logic [31:0]   dmem_addr_q, dmem_addr_d;
   logic [3:0]    dmem_be_q, dmem_be_d;
   logic [31:0]   dmem_wdata_q, dmem_wdata_d;
   logic [31:0]   read_data_q, read_data_d;
   logic          bus_error_q, bus_error_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [1:0]    lane_q, lane_d;

   logic          access;
   logic          misaligned;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_ext;

   assign access     = valid & (MemRead | MemWrite);
   assign misaligned = (mem_size == 2'b11)
                     | ((mem_size == 2'b01) & alu_result[0])
                     | ((mem_size == 2'b10) & (|alu_result[1:0]));

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = write_data;
      case (mem_size)
         2'b00: begin
            be_calc    = 4'b0001 << alu_result[1:0];
            wdata_calc = {4{write_data[7:0]}};
         end
         2'b01: begin
            be_calc    = 4'b0011 << alu_result[1:0];
            wdata_calc = {2{write_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Extraction uses the size/lane latched at issue, not the live EX/MEM inputs.
   assign byte_sel = dmem_rdata[{lane_q, 3'b000} +: 8];
   assign half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      load_ext = dmem_rdata;
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_be_d    = dmem_be_q;
      dmem_wdata_d = dmem_wdata_q;
      read_data_d  = read_data_q;
      bus_error_d  = 1'b0;
      size_d       = size_q;
      uns_d        = uns_q;
      lane_d       = lane_q;
      case (state_q)
         S_IDLE: begin
            if (access && !misaligned) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = MemWrite & ~MemRead;
               dmem_addr_d  = {alu_result[31:2], 2'b00};
               dmem_be_d    = be_calc;
               dmem_wdata_d = wdata_calc;
               size_d       = mem_size;
               uns_d        = mem_unsigned;
               lane_d       = alu_result[1:0];
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            if (dmem_ack) begin
               dmem_req_d = 1'b0;
               cnt_d      = '0;
               state_d    = S_DONE;
               if (!dmem_we_q) read_data_d = load_ext;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               dmem_req_d  = 1'b0;
               bus_error_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_DONE;
               if (!dmem_we_q) read_data_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
         read_data_q  <= '0;
         bus_error_q  <= 1'b0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         lane_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_be_q    <= dmem_be_d;
         dmem_wdata_q <= dmem_wdata_d;
         read_data_q  <= read_data_d;
         bus_error_q  <= bus_error_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         lane_q       <= lane_d;
      end
   end

   // Reset gating keeps the stall low even while a live access is presented.
   assign mem_stall       = reset & (((state_q == S_IDLE) & access & ~misaligned)
                                     | (state_q == S_REQ));
   assign addr_misaligned = reset & (state_q == S_IDLE) & access & misaligned;

   assign ReadData   = read_data_q;
   assign bus_error  = bus_error_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table-driven accesses plus hand-written
// misaligned, timeout, stray-ack and mid-transaction reset sequences.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        valid;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] alu_result;
   logic [31:0] write_data;
   logic        mem_stall;
   logic [31:0] ReadData;
   logic        addr_misaligned;
   logic        bus_error;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_rd;

   mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .valid(valid), .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result(alu_result),
      .write_data(write_data), .mem_stall(mem_stall), .ReadData(ReadData),
      .addr_misaligned(addr_misaligned), .bus_error(bus_error), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic exp_we;
      exp_we       = v.wr & ~v.rd;
      valid        = 1'b1;
      MemRead      = v.rd;
      MemWrite     = v.wr;
      mem_size     = v.size;
      mem_unsigned = v.uns;
      alu_result   = v.addr;
      write_data   = v.wdata;
      dmem_ack     = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_stall_idle", idx), 32'(mem_stall), 32'd1);
      step();
      chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'd1);
      chk($sformatf("v%0d_addr", idx), dmem_addr, v.exp_addr);
      chk($sformatf("v%0d_be", idx), 32'(dmem_be), 32'(v.exp_be));
      chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(exp_we));
      if (exp_we) chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d_stall_req", idx), 32'(mem_stall), 32'd1);
      step();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      if (!exp_we) exp_rd = v.exp_rd;
      chk($sformatf("v%0d_readdata", idx), ReadData, exp_rd);
      chk($sformatf("v%0d_stall_done", idx), 32'(mem_stall), 32'd0);
      chk($sformatf("v%0d_req_done", idx), 32'(dmem_req), 32'd0);
      step();
      valid    = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   initial begin
      int req_cycles;
      int berr_in_req;
      int guard;
      int req_seen;

      //          rd    wr    size   uns   addr          wdata         rdata         be       addr          wdata         readdata
      vecs[0] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
      vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h8011_2233, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080};
      vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_1234, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
      vecs[5] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'h0,        32'h0000_F00D, 4'b0011, 32'h0000_0100, 32'h0,        32'h0000_F00D};
      vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h1234_56A5, 32'h0,        4'b0010, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_007F};
      vecs[8] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        4'b1111, 32'h0000_0400, 32'hCAFE_F00D, 32'h0};
      vecs[9] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h9999_9999, 32'h1122_3344, 4'b1111, 32'h0000_0104, 32'h0,        32'h1122_3344};

      reset        = 1'b0;
      valid        = 1'b1;
      MemRead      = 1'b1;
      MemWrite     = 1'b0;
      mem_size     = 2'b10;
      mem_unsigned = 1'b0;
      alu_result   = 32'h0000_0100;
      write_data   = 32'h0;
      dmem_ack     = 1'b0;
      dmem_rdata   = 32'h0;
      exp_rd       = 32'h0;

      // Reset state with a live access presented
      @(negedge clk);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_readdata", ReadData, 32'd0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_berr", 32'(bus_error), 32'd0);
      alu_result = 32'h0000_0101;
      @(negedge clk);
      chk("rst_misaligned", 32'(addr_misaligned), 32'd0);
      valid = 1'b0;
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Misaligned accesses never reach the bus
      req_seen     = 0;
      valid        = 1'b1;
      MemRead      = 1'b1;
      MemWrite     = 1'b0;
      mem_size     = 2'b10;
      alu_result   = 32'h0000_0101;
      @(negedge clk);
      chk("mis_lw_flag", 32'(addr_misaligned), 32'd1);
      chk("mis_lw_stall", 32'(mem_stall), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         if (dmem_req) req_seen++;
      end
      mem_size   = 2'b01;
      alu_result = 32'h0000_0103;
      @(negedge clk);
      chk("mis_lh_flag", 32'(addr_misaligned), 32'd1);
      mem_size   = 2'b11;
      alu_result = 32'h0000_0000;
      MemRead    = 1'b0;
      MemWrite   = 1'b1;
      @(negedge clk);
      chk("mis_size11_flag", 32'(addr_misaligned), 32'd1);
      step();
      if (dmem_req) req_seen++;
      chk("mis_no_req", 32'(req_seen), 32'd0);
      chk("mis_readdata", ReadData, exp_rd);
      valid = 1'b0;
      @(negedge clk);
      chk("mis_flag_clear", 32'(addr_misaligned), 32'd0);

      // Ack outside REQ is ignored
      step();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h7777_7777;
      step();
      step();
      chk("stray_ack_req", 32'(dmem_req), 32'd0);
      chk("stray_ack_readdata", ReadData, exp_rd);
      dmem_ack = 1'b0;

      // Load with no ack times out after 16 REQ cycles
      valid      = 1'b1;
      MemRead    = 1'b1;
      MemWrite   = 1'b0;
      mem_size   = 2'b10;
      alu_result = 32'h0000_0500;
      step();
      req_cycles  = 0;
      berr_in_req = 0;
      guard       = 0;
      while (dmem_req && guard < 40) begin
         req_cycles++;
         if (bus_error) berr_in_req++;
         step();
         guard++;
      end
      exp_rd = 32'h0;
      chk("to_req_cycles", 32'(req_cycles), 32'd16);
      chk("to_berr_early", 32'(berr_in_req), 32'd0);
      chk("to_berr_pulse", 32'(bus_error), 32'd1);
      chk("to_readdata", ReadData, exp_rd);
      chk("to_stall_done", 32'(mem_stall), 32'd0);
      valid = 1'b0;
      step();
      chk("to_berr_clear", 32'(bus_error), 32'd0);
      chk("to_idle_req", 32'(dmem_req), 32'd0);

      // Establish a nonzero ReadData, then reset during the 2nd REQ cycle
      run_vec(vecs[0], 10);
      valid      = 1'b1;
      MemRead    = 1'b1;
      MemWrite   = 1'b0;
      mem_size   = 2'b10;
      alu_result = 32'h0000_0600;
      step();
      step();
      chk("rr_req_before", 32'(dmem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("rr_req_drop", 32'(dmem_req), 32'd0);
      chk("rr_stall_drop", 32'(mem_stall), 32'd0);
      chk("rr_readdata", ReadData, 32'd0);
      exp_rd = 32'h0;
      valid  = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk("rr_idle_stall", 32'(mem_stall), 32'd0);
      run_vec(vecs[9], 11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine of the 5-stage MIPS32 pipeline.
- Takes the EX/MEM access request (address, store data, size, sign) and drives a req/ack data-memory bus.
- Aligns and extends load data, then presents it as ReadData to the MEM/WB pipeline register.
- Stalls the pipeline until the bus transaction completes or times out.

Parameters:
- TIMEOUT_CYCLES, 16: max REQ cycles without dmem_ack before bus_error; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- reset  input  1  Asynchronous, active-low reset.
- valid  input  1  EX/MEM holds a live instruction.
- MemRead  input  1  Load request.
- MemWrite  input  1  Store request.
- mem_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned  input  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- alu_result  input  32  Byte address.
- write_data  input  32  Store data, right-justified.
- mem_stall  output  1  Freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB.
- ReadData  output  32  Extended load result to MEM_WB.
- addr_misaligned  output  1  Misaligned or illegal-size access seen this cycle.
- bus_error  output  1  Registered one-cycle pulse on timeout.
- dmem_req  output  1  Bus request, registered.
- dmem_we  output  1  Bus write enable, registered.
- dmem_addr  output  32  Word address {addr[31:2],2'b00}, registered.
- dmem_be  output  4  Byte enables, little-endian, registered.
- dmem_wdata  output  32  Lane-replicated store data, registered.
- dmem_ack  input  1  Bus completion; valid only while dmem_req=1.
- dmem_rdata  input  32  Read word; valid with dmem_ack.

Behaviour:
- Reset (reset=0, async): state IDLE, timeout counter=0, every registered output =0. mem_stall and addr_misaligned evaluate to 0 in IDLE with reset asserted. A reset during REQ drops dmem_req immediately; the transaction is abandoned.
- An access exists when valid & (MemRead|MemWrite). If both are high, it is a read; no write is performed.
- Misaligned: size 01 with addr[0]=1; size 10 with addr[1:0]!=0; any size 11.
- State IDLE:
  - Misaligned access: addr_misaligned=1 (combinational), mem_stall=0, no bus request, ReadData unchanged. Stay in IDLE.
  - Aligned access: mem_stall=1 (combinational). Register dmem_addr/be/we/wdata and set dmem_req=1. Go to REQ.
  - No access: mem_stall=0, stay in IDLE.
- State REQ:
  - mem_stall=1; bus outputs stable.
  - On dmem_ack: dmem_req←0. For a read, ReadData←extracted/extended dmem_rdata. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: dmem_req←0, bus_error pulses for one cycle. For a read, ReadData←0. Go to DONE.
  - The counter increments each REQ cycle and clears on leaving REQ.
- State DONE: mem_stall=0 so the pipeline advances at this edge and MEM_WB captures ReadData. Go to IDLE unconditionally. No new request is issued in DONE, which prevents re-issuing the still-present instruction.
- Minimum latency: 3 cycles per aligned access (IDLE, REQ with same-cycle ack, DONE), i.e. 2 stall cycles.
- Byte enables and store data (a = addr[1:0]):
  - byte: be = 4'b0001<<a; wdata = {4{wd[7:0]}}.
  - half: be = 4'b0011<<a; wdata = {2{wd[15:0]}}.
  - word: be = 4'b1111; wdata = wd.
  - Reads use the same be.
- Load extraction:
  - byte: lane a.
  - half: lane pair a[1].
  - Sign bit = the extracted MSB unless mem_unsigned=1.
- ReadData holds its value until the next completed read. Stores never change it.
- dmem_ack outside REQ is ignored.

Test Plan:
- Word load addr 0x100, rdata 0xDEADBEEF, ack on first REQ cycle -> dmem_addr 0x100, be 1111, mem_stall high 2 cycles, ReadData 0xDEADBEEF in DONE.
- lb addr 0x103, rdata 0x80112233, signed -> be 1000, ReadData 0xFFFFFF80. Same with mem_unsigned=1 -> 0x00000080.
- sh addr 0x202, write_data 0x0000ABCD -> dmem_we 1, be 1100, wdata 0xABCDABCD, addr 0x200, ReadData unchanged.
- lw addr 0x101 -> addr_misaligned 1 for that cycle, mem_stall 0, dmem_req never asserted.
- Load with no ack, TIMEOUT_CYCLES=16 -> dmem_req high 16 cycles, bus_error one-cycle pulse, ReadData 0, DONE then IDLE.
- reset asserted on the 2nd REQ cycle -> dmem_req and mem_stall 0 immediately. After release, the unit is in IDLE and the next lw completes normally.
